pll_rst_seq_ctrl: RTL

- Sequences the clock-generation PLLs and the per-domain resets that follow them.
- Drives the PLL reset and qualifies the PLL lock signal.
- Releases the domain resets one at a time, in a fixed order.
- Watches for lock loss and software reset requests, restarts the sequence when either occurs, and reports status.
- Sits between the clock/reset generation wrappers and the rest of the board logic, clocked by the free-running reference clock.

---
 rtl/pll_rst_seq_pkg.sv | 25 ++
 rtl/rst_seq_sync_2ff.sv | 27 ++
 rtl/pll_rst_seq_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/pll_rst_seq_pkg.sv
// Shared state encoding, simulation-mode timing overrides and counter width
// for the PLL / domain reset sequencer.
package pll_rst_seq_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAIL      = 3'd5
  } seq_state_e;

  localparam int SIM_PLL_RST_CYC      = 8;
  localparam int SIM_LOCK_STABLE_CYC  = 16;
  localparam int SIM_LOCK_TIMEOUT_CYC = 64;

  localparam int CNT_W = 32;

  // Saturating increment for the 8-bit lock-loss event counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/rst_seq_sync_2ff.sv
// Two-flop synchroniser with asynchronous active-low reset, used to bring
// the PLL lock indication into the reference clock domain.
module rst_seq_sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_rst_seq_ctrl.sv
// PLL reset / lock qualification and ordered release of per-domain resets.
// Optional macro PLL_RST_RETRY_EN: retry the PLL reset on lock timeout before FAIL.
module pll_rst_seq_ctrl
  import pll_rst_seq_pkg::*;
#(
  parameter int    U_DLY            = 1,
  parameter string SIMULATION       = "FALSE",
  parameter int    DOM_NUM          = 3,
  parameter int    PLL_RST_CYC      = 100,
  parameter int    LOCK_STABLE_CYC  = 1000,
  parameter int    LOCK_TIMEOUT_CYC = 100000,
  parameter int    REL_GAP_CYC      = 16,
  parameter int    RETRY_MAX        = 3
) (
  input  logic               clk_sys,
  input  logic               rst_n,
  input  logic               pll_locked,
  input  logic               soft_rst_en,
  output logic               rst_pll,
  output logic [DOM_NUM-1:0] dom_rst_n,
  output logic               seq_done,
  output logic               seq_fail,
  output logic [7:0]         lock_loss_cnt,
  output logic [2:0]         seq_state
);

  localparam bit IS_SIM      = (SIMULATION == "TRUE");
  localparam int RST_CYC_I   = IS_SIM ? SIM_PLL_RST_CYC      : PLL_RST_CYC;
  localparam int STB_CYC_I   = IS_SIM ? SIM_LOCK_STABLE_CYC  : LOCK_STABLE_CYC;
  localparam int TO_CYC_I    = IS_SIM ? SIM_LOCK_TIMEOUT_CYC : LOCK_TIMEOUT_CYC;

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYC_I - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STB_CYC_I - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TO_CYC_I - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(REL_GAP_CYC - 1);
  localparam logic [2:0]       IDX_LAST = 3'(DOM_NUM - 1);

  seq_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         dom_idx_q, dom_idx_d;
  logic [DOM_NUM-1:0] dom_rst_n_q, dom_rst_n_d;
  logic               rst_pll_q, rst_pll_d;
  logic               seq_done_q, seq_done_d;
  logic               seq_fail_q, seq_fail_d;
  logic [7:0]         llc_q, llc_d;
  logic               soft_q;
  logic               soft_req;
  logic               lock_s;
  logic               abort;
  logic [DOM_NUM-1:0] rel_bit;
  logic [31:0]        cfg_unused;

`ifdef PLL_RST_RETRY_EN
  localparam logic [7:0] RETRY_LAST = 8'(RETRY_MAX);
  logic [7:0] retry_q, retry_d;
  // Register timing is zero-delay; U_DLY is kept only for drop-in compatibility.
  assign cfg_unused = 32'(U_DLY);
`else
  assign cfg_unused = 32'(U_DLY) ^ 32'(RETRY_MAX);
`endif

  rst_seq_sync_2ff #(
    .WIDTH (1)
  ) u_lock_sync (
    .clk_i  (clk_sys),
    .rst_ni (rst_n),
    .d_i    (pll_locked),
    .q_o    (lock_s)
  );

  assign soft_req = soft_rst_en & ~soft_q;
  assign rel_bit  = DOM_NUM'(1) << dom_idx_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dom_idx_d   = dom_idx_q;
    dom_rst_n_d = dom_rst_n_q;
    llc_d       = llc_q;
    abort       = 1'b0;
`ifdef PLL_RST_RETRY_EN
    retry_d     = retry_q;
`endif

    if (soft_req && (state_q != ST_FAIL)) begin
      abort = 1'b1;
    end else begin
      unique case (state_q)
        ST_PLL_RST: begin
          if (cnt_q == RST_LAST) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TO_LAST) begin
`ifdef PLL_RST_RETRY_EN
            if (retry_q == RETRY_LAST) begin
              state_d = ST_FAIL;
              cnt_d   = '0;
            end else begin
              abort   = 1'b1;
              retry_d = retry_q + 8'd1;
            end
`else
            state_d = ST_FAIL;
            cnt_d   = '0;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_STABLE: begin
          // A single low lock sample restarts the wait without re-pulsing the PLL.
          if (!lock_s) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STB_LAST) begin
            state_d = ST_RELEASE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          if (!lock_s) begin
            abort = 1'b1;
            llc_d = sat_inc8(llc_q);
          end else if (cnt_q == GAP_LAST) begin
            dom_rst_n_d = dom_rst_n_q | rel_bit;
            dom_idx_d   = dom_idx_q + 3'd1;
            cnt_d       = '0;
            if (dom_idx_q == IDX_LAST) begin
              state_d = ST_RUN;
`ifdef PLL_RST_RETRY_EN
              retry_d = '0;
`endif
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            abort = 1'b1;
            llc_d = sat_inc8(llc_q);
          end
        end
        ST_FAIL: begin
          if (soft_req) begin
            abort = 1'b1;
`ifdef PLL_RST_RETRY_EN
            retry_d = '0;
`endif
          end
        end
        default: begin
          abort = 1'b1;
        end
      endcase
    end

    if (abort) begin
      state_d   = ST_PLL_RST;
      cnt_d     = '0;
      dom_idx_d = '0;
    end

    if ((state_d != ST_RELEASE) && (state_d != ST_RUN)) begin
      dom_rst_n_d = '0;
    end

    rst_pll_d  = (state_d == ST_PLL_RST) || (state_d == ST_FAIL);
    seq_done_d = (state_d == ST_RUN);
    seq_fail_d = (state_d == ST_FAIL);
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_PLL_RST;
      cnt_q       <= '0;
      dom_idx_q   <= '0;
      dom_rst_n_q <= '0;
      rst_pll_q   <= 1'b1;
      seq_done_q  <= 1'b0;
      seq_fail_q  <= 1'b0;
      llc_q       <= '0;
      soft_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dom_idx_q   <= dom_idx_d;
      dom_rst_n_q <= dom_rst_n_d;
      rst_pll_q   <= rst_pll_d;
      seq_done_q  <= seq_done_d;
      seq_fail_q  <= seq_fail_d;
      llc_q       <= llc_d;
      soft_q      <= soft_rst_en;
    end
  end

`ifdef PLL_RST_RETRY_EN
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      retry_q <= '0;
    end else begin
      retry_q <= retry_d;
    end
  end
`endif

  assign rst_pll       = rst_pll_q;
  assign dom_rst_n     = dom_rst_n_q;
  assign seq_done      = seq_done_q;
  assign seq_fail      = seq_fail_q;
  assign lock_loss_cnt = llc_q;
  assign seq_state     = state_q;

endmodule
